// File: rtl/mmio_uart_tx_if.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_if
//   Data-store bus seen by the memory-mapped UART transmitter.
//   Signals:
//     MemWrite   store strobe from the core
//     DataAdr    32-bit store/load address
//     WriteData  32-bit store data
//     ReadData   32-bit status word returned on the load path
//   Modports:
//     master  : the core side (drives address/data/strobe, reads status)
//     slave   : the UART side (samples address/data/strobe, returns status)
// -----------------------------------------------------------------------------
interface mmio_uart_tx_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport master (
      output MemWrite,
      output DataAdr,
      output WriteData,
      input  ReadData
   );

   modport slave (
      input  MemWrite,
      input  DataAdr,
      input  WriteData,
      output ReadData
   );
endinterface : mmio_uart_tx_if

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped UART transmitter. Byte stores to TX_ADDR are queued in a
//   small FIFO and sent as 8N1 frames on tx, LSB first. A status word
//   {overflow, full, busy} is returned on the load path at STATUS_ADDR; a
//   store there with WriteData[2]=1 clears the sticky overflow flag.
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-high reset
//     bus    slave modport of mmio_uart_tx_if (MemWrite/DataAdr/WriteData in,
//            ReadData out, combinational status)
//     tx     out  serial line, idle high, driven from a flop
//     busy   out  FIFO non-empty or a frame in progress
//     full   out  FIFO holds FIFO_DEPTH entries
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
   parameter logic [31:0] TX_ADDR      = 32'hFFFF_FF00,
   parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FF04,
   parameter int          CLKS_PER_BIT = 4,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic                clk,
   input  logic                reset,
   mmio_uart_tx_if.slave       bus,
   output logic                tx,
   output logic                busy,
   output logic                full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
   localparam logic [AW:0]   PTR_ZERO  = (AW+1)'(0);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   // FIFO storage and pointers (one extra MSB distinguishes full from empty)
   logic [7:0]  fifo_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        ovf_q, ovf_d;

   // Transmit engine
   state_e       state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]   bit_idx_q, bit_idx_d;
   logic [7:0]   shift_q, shift_d;
   logic         tx_q, tx_d;

   logic empty_s;
   logic full_s;
   logic push_req_s;
   logic push_s;
   logic pop_s;
   logic clr_s;
   logic unused_wdata_s;

   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Full is judged on the registered pointers, so a push while full is
   // dropped even if the engine pops on the same edge.
   assign push_req_s = bus.MemWrite && (bus.DataAdr == TX_ADDR);
   assign push_s     = push_req_s && !full_s;
   assign clr_s      = bus.MemWrite && (bus.DataAdr == STATUS_ADDR) && bus.WriteData[2];

   // Only the low byte and the clear bit of WriteData carry meaning.
   assign unused_wdata_s = ^bus.WriteData[31:8];

   assign tx   = tx_q;
   assign full = full_s;
   assign busy = (state_q != S_IDLE) || !empty_s;

   // Status word on the load path
   always_comb begin
      bus.ReadData = 32'h0000_0000;
      if (bus.DataAdr == STATUS_ADDR) begin
         bus.ReadData = {29'b0, ovf_q, full_s, busy};
      end else begin
         bus.ReadData = 32'h0000_0000;
      end
   end

   // FIFO pointer and overflow next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      // Set and clear come from different addresses and never coincide.
      if (push_req_s && full_s) begin
         ovf_d = 1'b1;
      end else if (clr_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // FIFO data array; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= bus.WriteData[7:0];
      end
   end

   // Transmit FSM next-state and serial output
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop_s     = 1'b0;
      tx_d      = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_q[rd_ptr_q[AW-1:0]];
               baud_d  = BAUD_ZERO;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = BAUD_ZERO;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = BAUD_ZERO;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         S_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = BAUD_ZERO;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = BAUD_ZERO;
         end
      endcase

      // tx is registered from the upcoming state so the line level tracks
      // the state without a combinational path to the pin.
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         S_IDLE:  tx_d = 1'b1;
         S_STOP:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // State, pointer and line registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         baud_q    <= BAUD_ZERO;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         wr_ptr_q  <= PTR_ZERO;
         rd_ptr_q  <= PTR_ZERO;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule : mmio_uart_tx

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
//   Accepted stores push the expected byte; a serial-line monitor decodes each
//   frame, pops the expected byte and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mmio_uart_tx;

   localparam logic [31:0] TX_ADDR     = 32'hFFFF_FF00;
   localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FF04;
   localparam int          DEPTH       = 8;

   logic clk;
   logic reset;
   logic tx;
   logic busy;
   logic full;

   mmio_uart_tx_if bus_if ();

   mmio_uart_tx #(
      .TX_ADDR      (TX_ADDR),
      .STATUS_ADDR  (STATUS_ADDR),
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .tx    (tx),
      .busy  (busy),
      .full  (full)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Scoreboard and model state
   logic [7:0] exp_q[$];
   int         starts[$];
   int         acc_cnt    = 0;   // bytes accepted (main process)
   int         pop_cnt    = 0;   // frames started (monitor process)
   logic       model_ovf  = 1'b0;
   int         frames_seen = 0;

   // Monitor state
   logic       mon_active = 1'b0;
   int         mon_t      = 0;
   logic [7:0] mon_rx     = 8'h00;
   logic [7:0] mon_exp    = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int model_occ();
      return acc_cnt - pop_cnt;
   endfunction

   function automatic logic [31:0] model_status();
      logic b;
      b = (model_occ() != 0) || mon_active;
      return {29'b0, model_ovf, (model_occ() == DEPTH), b};
   endfunction

   // One store on the next rising edge; model updated after that edge
   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      bus_if.MemWrite  = 1'b1;
      bus_if.DataAdr   = addr;
      bus_if.WriteData = data;
      @(posedge clk);
      if (addr == TX_ADDR) begin
         if (model_occ() < DEPTH) begin
            exp_q.push_back(data[7:0]);
            acc_cnt++;
         end else begin
            model_ovf = 1'b1;
         end
      end else if (addr == STATUS_ADDR && data[2]) begin
         model_ovf = 1'b0;
      end
      #1;
      bus_if.MemWrite  = 1'b0;
      bus_if.DataAdr   = 32'h0;
      bus_if.WriteData = 32'h0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("drain", 32'(exp_q.size()) + 32'(mon_active), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   // Serial-line monitor: decodes frames sampling mid-bit on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         mon_active = 1'b0;
         mon_t      = 0;
         pop_cnt    = 0;
      end else if (!mon_active) begin
         if (tx == 1'b0) begin
            mon_active = 1'b1;
            mon_t      = 0;
            frames_seen++;
            starts.push_back(cyc);
            check_val("frame_queued", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_exp = exp_q.pop_front();
               pop_cnt++;
            end else begin
               mon_exp = 8'h00;
            end
         end
      end else begin
         mon_t++;
         if (mon_t == 2) begin
            check_val("start_bit", 32'(tx), 32'd0);
         end else if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 2) % 4) == 0) begin
            mon_rx[(mon_t - 6) / 4] = tx;
         end else if (mon_t == 38) begin
            check_val("stop_bit", 32'(tx), 32'd1);
            check_val("rx_byte", 32'(mon_rx), 32'(mon_exp));
         end else if (mon_t == 39) begin
            mon_active = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       exp_tx;
      int         frames_before;

      reset            = 1'b1;
      bus_if.MemWrite  = 1'b0;
      bus_if.DataAdr   = 32'h0;
      bus_if.WriteData = 32'h0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // 1. Reset state
      bus_if.DataAdr = STATUS_ADDR;
      #1;
      check_val("rst_tx",     32'(tx),   32'd1);
      check_val("rst_busy",   32'(busy), 32'd0);
      check_val("rst_full",   32'(full), 32'd0);
      check_val("rst_status", bus_if.ReadData, 32'h0);
      @(posedge clk);
      #1;

      // 2. Single byte 0x55 with exact bit timing
      b = 8'h55;
      store(TX_ADDR, 32'(b));
      @(negedge clk);
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         if (k <= 4)       exp_tx = 1'b0;
         else if (k <= 36) exp_tx = b[(k - 5) / 4];
         else              exp_tx = 1'b1;
         check_val($sformatf("t2_tx_c%0d", k), 32'(tx), 32'(exp_tx));
         if (k == 40) check_val("t2_busy_c40", 32'(busy), 32'd1);
         if (k == 41) check_val("t2_busy_c41", 32'(busy), 32'd0);
      end
      wait_drain(200);

      // 3. Store to another address and an address match without MemWrite
      frames_before = frames_seen;
      store(32'hFFFF_FF08, 32'h0000_00AA);
      bus_if.MemWrite  = 1'b0;
      bus_if.DataAdr   = TX_ADDR;
      bus_if.WriteData = 32'h0000_00BB;
      repeat (50) @(negedge clk);
      check_val("t3_tx",     32'(tx),   32'd1);
      check_val("t3_busy",   32'(busy), 32'd0);
      check_val("t3_frames", 32'(frames_seen), 32'(frames_before));
      @(posedge clk);
      #1;
      bus_if.DataAdr   = 32'h0;
      bus_if.WriteData = 32'h0;

      // 4. Ten back-to-back stores: fill, overflow, ordered drain
      starts.delete();
      for (int i = 0; i < 10; i++) begin
         store(TX_ADDR, 32'(i + 1));
         check_val($sformatf("t4_full_%0d", i), 32'(full), 32'(model_occ() == DEPTH));
      end
      bus_if.DataAdr = STATUS_ADDR;
      #1;
      check_val("t4_status", bus_if.ReadData, model_status());
      bus_if.DataAdr = TX_ADDR;
      #1;
      check_val("t4_rd_other_addr", bus_if.ReadData, 32'h0);

      // 5. Clear overflow while full and busy
      store(STATUS_ADDR, 32'h0000_0004);
      bus_if.DataAdr = STATUS_ADDR;
      #1;
      check_val("t5_status", bus_if.ReadData, model_status());
      bus_if.DataAdr = 32'h0;
      wait_drain(2000);
      check_val("t4_frames", 32'(starts.size()), 32'd9);
      for (int i = 1; i < starts.size(); i++) begin
         check_val($sformatf("t4_gap_%0d", i), 32'(starts[i] - starts[i-1]), 32'd41);
      end

      // 6. Reset in the middle of a data bit with three bytes queued
      store(TX_ADDR, 32'h11);
      store(TX_ADDR, 32'h22);
      store(TX_ADDR, 32'h33);
      store(TX_ADDR, 32'h44);
      repeat (15) @(posedge clk);
      #2 reset = 1'b1;
      exp_q.delete();
      acc_cnt   = 0;
      model_ovf = 1'b0;
      bus_if.DataAdr = STATUS_ADDR;
      #1;
      check_val("t6_tx",     32'(tx),   32'd1);
      check_val("t6_busy",   32'(busy), 32'd0);
      check_val("t6_full",   32'(full), 32'd0);
      check_val("t6_status", bus_if.ReadData, 32'h0);
      frames_before = frames_seen;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (100) @(negedge clk);
      check_val("t6_tx_after",     32'(tx),   32'd1);
      check_val("t6_busy_after",   32'(busy), 32'd0);
      check_val("t6_frames_after", 32'(frames_seen), 32'(frames_before));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_mmio_uart_tx
